// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
//  Module   : wave_capture
//  Purpose  : Decimating, edge/auto-triggered waveform capture into a
//             2^AW-sample circular buffer with a pre-trigger window and a
//             registered display read port.
//  Revision : 1.0  initial release
// ============================================================================
module wave_capture #(
    parameter int DW      = 8,
    parameter int AW      = 10,
    parameter int PRE     = 256,
    parameter int AUTO_TO = 4096
) (
    input  logic          sys_clk,
    input  logic          rstn,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    input  logic [3:0]    div_sel,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_edge,
    input  logic          auto_en,
    input  logic          rearm,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          frame_ready,
    output logic          trig_auto,
    output logic          busy
);

    localparam int TW     = $clog2(AUTO_TO + 1);
    localparam int POST_N = (1 << AW) - PRE - 1;

    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TO - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Settings latched at rearm so a capture is not disturbed by live changes
    logic [3:0]    div_lat;
    logic          edge_lat;

    logic [14:0]   dec_cnt;
    logic [14:0]   dec_mask;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_cnt;
    logic [TW-1:0] to_cnt;
    logic [DW-1:0] prev;
    logic [AW-1:0] win_start;
    logic [AW-1:0] rd_ptr;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic capturing;
    logic dsample;
    logic wr_en;
    logic cross_rise;
    logic cross_fall;
    logic level_hit;
    logic force_hit;
    logic trig_now;

    assign dec_mask   = 15'((16'd1 << div_lat) - 16'd1);
    assign capturing  = (state == PREFILL) || (state == ARMED) || (state == POST);
    assign dsample    = adc_valid && (dec_cnt == 15'd0);
    // A rearm in the same cycle takes precedence over any write or trigger
    assign wr_en      = capturing && dsample && !rearm;
    assign cross_rise = (prev < trig_level) && (adc_data >= trig_level);
    assign cross_fall = (prev >= trig_level) && (adc_data < trig_level);
    assign level_hit  = edge_lat ? cross_fall : cross_rise;
    assign force_hit  = auto_en && (to_cnt == TO_LAST);
    assign trig_now   = (state == ARMED) && dsample && (level_hit || force_hit);
    assign rd_ptr     = win_start + rd_addr;

    // State register
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        next_state  = state;
        busy        = capturing;
        frame_ready = (state == DONE);
        if (rearm) begin
            next_state = PREFILL;
        end else begin
            case (state)
                PREFILL: if (dsample && (pre_cnt == PRE_LAST))   next_state = ARMED;
                ARMED:   if (trig_now)                           next_state = POST;
                POST:    if (dsample && (post_cnt == POST_LAST)) next_state = DONE;
                default: next_state = state;
            endcase
        end
    end

    // Decimation, address, phase counters, trigger history and window origin
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            div_lat   <= 4'd0;
            edge_lat  <= 1'b0;
            dec_cnt   <= 15'd0;
            wr_addr   <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            to_cnt    <= '0;
            prev      <= '0;
            win_start <= '0;
            trig_auto <= 1'b0;
        end else if (rearm) begin
            div_lat   <= div_sel;
            edge_lat  <= trig_edge;
            dec_cnt   <= 15'd0;
            wr_addr   <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            to_cnt    <= '0;
            trig_auto <= 1'b0;
        end else begin
            if (adc_valid) begin
                dec_cnt <= 15'(dec_cnt + 15'd1) & dec_mask;
            end
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
                prev    <= adc_data;
                case (state)
                    PREFILL: pre_cnt <= pre_cnt + 1'b1;
                    ARMED: begin
                        // Saturate so a disabled auto-trigger never wraps around
                        if (to_cnt != TO_LAST) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        if (trig_now) begin
                            win_start <= wr_addr - PRE_OFS;
                            if (force_hit) begin
                                trig_auto <= 1'b1;
                            end
                        end
                    end
                    POST:    post_cnt <= post_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Sample buffer write port (contents deliberately not reset)
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= adc_data;
        end
    end

    // Registered read port, indexed relative to the oldest frame sample
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule
`default_nettype wire
